// File: rtl/mmx_pkg.sv
// rtl/mmx_pkg.sv - shared widths and sequencing states for the multiplication-table generator
package mmx_pkg;
  localparam int OP_W      = 6;
  localparam int CNT_W     = 8;
  localparam int PROD_W    = 14;
  localparam int MUL_STEPS = 6;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    MUL     = 2'd1,
    DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/mmx_serial_mul.sv
// rtl/mmx_serial_mul.sv - serial shift-add multiplier, one operand bit per clock
module mmx_serial_mul
  import mmx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] prod,
  output logic              done
);
  logic [PROD_W-1:0] a_sh;
  logic [PROD_W-1:0] acc;
  logic [OP_W-1:0]   b_reg;
  logic [2:0]        step;
  logic              busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      acc   <= '0;
      b_reg <= '0;
      step  <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      a_sh  <= {{(PROD_W-CNT_W){1'b0}}, a};
      acc   <= '0;
      b_reg <= b;
      step  <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      if (b_reg[0])
        acc <= acc + a_sh;
      a_sh  <= a_sh << 1;
      b_reg <= b_reg >> 1;
      step  <= step + 3'd1;
      if (step == 3'(MUL_STEPS - 1))
        busy <= 1'b0;
    end
  end

  // done marks the cycle of the final add; prod is complete one edge later
  assign done = busy && (step == 3'(MUL_STEPS - 1));
  assign prod = acc;
endmodule

// File: rtl/mmx_chip.sv
// rtl/mmx_chip.sv - pin-limited n*B table generator top; MMX_SATURATE_EN clamps results above 255
module mmx_chip
  import mmx_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_INIT = 8'd0,
  parameter logic [CNT_W-1:0] CNT_STEP = 8'd1
)(
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  logic              clk;
  logic              rst_n;
  logic [OP_W-1:0]   b_pin;
  state_t            state;
  logic [CNT_W-1:0]  n;
  logic [7:0]        out_r;
  logic [PROD_W-1:0] prod;
  logic              mul_done;
  logic [7:0]        result;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign b_pin = io_in[7:2];

  mmx_serial_mul u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == CAPTURE),
    .a     (n),
    .b     (b_pin),
    .prod  (prod),
    .done  (mul_done)
  );

`ifdef MMX_SATURATE_EN
  assign result = (prod > PROD_W'(255)) ? 8'hFF : prod[7:0];
`else
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod[PROD_W-1:8];
  assign result = prod[7:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CAPTURE;
      n     <= CNT_INIT;
      out_r <= 8'h00;
    end else begin
      case (state)
        CAPTURE: state <= MUL;
        MUL:     if (mul_done) state <= DONE;
        DONE: begin
          out_r <= result;
          n     <= n + CNT_STEP;
          state <= CAPTURE;
        end
        default: state <= CAPTURE;
      endcase
    end
  end

  assign io_out = out_r;
endmodule

// File: tb/tb_mmx_chip.sv
// tb/tb_mmx_chip.sv - directed and random checks of mmx_chip against an n*B arithmetic model
module tb_mmx_chip;
  localparam logic [7:0] CNT_INIT = 8'd0;
  localparam logic [7:0] CNT_STEP = 8'd1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] b = 6'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int total = 0;
  int bad = 0;
  int n_m;
  logic [7:0] prev;

  assign io_in = {b, rst_n, clk};

  mmx_chip #(.CNT_INIT(CNT_INIT), .CNT_STEP(CNT_STEP)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] expected(input int n, input int bv);
    int p;
    p = n * bv;
`ifdef MMX_SATURATE_EN
    return (p > 255) ? 8'hFF : 8'(p);
`else
    return 8'(p % 256);
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full 8-edge result period; B is presented for capture, then switched mid-multiply.
  task automatic one_result(input logic [5:0] b_cap, input logic [5:0] b_mid, input string tag);
    logic [7:0] e;
    b = b_cap;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) b = b_mid;
      if (k < 8) check({tag, "_hold"}, io_out, prev);
      else begin
        e = expected(n_m, int'(b_cap));
        check(tag, io_out, e);
        prev = e;
        n_m = (n_m + int'(CNT_STEP)) % 256;
      end
    end
  endtask

  task automatic pulse_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 check(tag, io_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    n_m  = int'(CNT_INIT);
    prev = 8'h00;
  endtask

  initial begin
    logic [5:0] r1, r2;
    b = 6'd63;
    #1 check("reset_async", io_out, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("reset_hold", io_out, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_m  = int'(CNT_INIT);
    prev = 8'h00;

    one_result(6'd3, 6'd3, "b3_n0");
    one_result(6'd3, 6'd3, "b3_n1");
    one_result(6'd3, 6'd3, "b3_n2");
    one_result(6'd17, 6'd17, "b17_n3");
    one_result(6'd63, 6'd63, "b63_n4");
    one_result(6'd63, 6'd63, "b63_n5_wrap_sat");
    one_result(6'd7, 6'd7, "b7_n6");

    b = 6'd9;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("pre_reset_hold", io_out, 8'h2A);
    end
    pulse_reset("reset_mid_mul");
    one_result(6'd9, 6'd9, "after_rst_n0");
    one_result(6'd9, 6'd9, "after_rst_n1");

    one_result(6'd3, 6'd5, "bchg_n2");
    one_result(6'd5, 6'd5, "bchg_n3");

    for (int i = 0; i < 24; i++) begin
      r1 = 6'($urandom);
      r2 = 6'($urandom);
      one_result(r1, r2, "random");
    end

    pulse_reset("reset_before_wrap");
    for (int i = 0; i < 257; i++)
      one_result(6'd1, 6'd1, "count_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
